// File: rtl/hazard_pkg.sv
// Shared types, constants and scoreboard helpers for the D-stage hazard controller.
package hazard_pkg;

  localparam int unsigned HZ_REG_AW    = 5;
  localparam int unsigned HZ_TW        = 2;
  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

  localparam logic [HZ_TW-1:0] TUSE_NONE = '1;
  localparam logic [HZ_TW-1:0] TNEW_ALU  = HZ_TW'(1);
  localparam logic [HZ_TW-1:0] TNEW_LOAD = HZ_TW'(2);
  localparam logic [HZ_TW-1:0] TNEW_LINK = HZ_TW'(0);

  typedef struct packed {
    logic [HZ_REG_AW-1:0] dst;
    logic [HZ_TW-1:0]     tnew;
  } stage_rec_t;

  // Advance a record one stage: result gets one cycle closer, floor at 0.
  function automatic stage_rec_t rec_age(input stage_rec_t r);
    stage_rec_t o;
    o.dst  = r.dst;
    o.tnew = (r.tnew != '0) ? r.tnew - HZ_TW'(1) : '0;
    return o;
  endfunction

  // True when a source operand needs a value some in-flight stage cannot yet forward.
  function automatic logic src_hazard(input logic [HZ_REG_AW-1:0] src,
                                      input logic [HZ_TW-1:0]     tuse,
                                      input stage_rec_t           e,
                                      input stage_rec_t           m,
                                      input stage_rec_t           w);
    logic hit;
    hit = ((e.dst == src) && (e.tnew > tuse)) ||
          ((m.dst == src) && (m.tnew > tuse)) ||
          ((w.dst == src) && (w.tnew > tuse));
    return (tuse != TUSE_NONE) && (src != '0) && hit;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Loadable down-counter tracking outstanding multiply/divide latency.
module md_busy_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load)
      w_cnt_nxt = i_load_val;
    else if (r_cnt != '0)
      w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  // Busy flag registered alongside the count so it is never a decode of the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew stall controller: shadow E/M/W destination records plus MDU busy interlock.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = HZ_REG_AW,
  parameter int unsigned TW       = HZ_TW,
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic              stall_rs,
  output logic              stall_rt,
  output logic              stall_md,
  output logic              busy
);

  stage_rec_t       r_e;
  stage_rec_t       r_m;
  stage_rec_t       r_w;
  logic             w_busy;
  logic             w_md_load;
  logic [CNT_W-1:0] w_md_val;

  assign stall_rs = d_valid & src_hazard(d_rs, d_tuse_rs, r_e, r_m, r_w);
  assign stall_rt = d_valid & src_hazard(d_rt, d_tuse_rt, r_e, r_m, r_w);
  assign stall_md = d_valid & d_md_use & w_busy;
  assign stall    = stall_rs | stall_rt | stall_md;
  assign busy     = w_busy;

  // A stalled D instruction becomes a bubble in E; older records age toward W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e <= (d_valid && !stall) ? stage_rec_t'{dst: d_dst, tnew: d_tnew} : '0;
      r_m <= rec_age(r_e);
      r_w <= rec_age(r_m);
    end
  end

  assign w_md_load = d_valid & d_md_start & ~stall;
  assign w_md_val  = d_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

  md_busy_cnt #(
    .CNT_W (CNT_W)
  ) u_md_busy_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_md_load),
    .i_load_val (w_md_val),
    .o_busy     (w_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl: per-cycle table plus divide and reset sequences.
module tb_hazard_ctrl;

  localparam logic [1:0] N = 2'd3;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [1:0] tu_rs;
    logic [4:0] rt;
    logic [1:0] tu_rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       mds;
    logic       mdd;
    logic       mdu;
    logic [4:0] exp;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, stall_rs, stall_rt, stall_md, busy;

  int   checks = 0;
  int   errors = 0;
  vec_t tv[$];

  hazard_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_dst      (d_dst),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .stall_rs   (stall_rs),
    .stall_rt   (stall_rt),
    .stall_md   (stall_md),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [1:0] tu_rs,
                              input logic [4:0] rt, input logic [1:0] tu_rt,
                              input logic [4:0] dst, input logic [1:0] tnew,
                              input logic mds, input logic mdd, input logic mdu,
                              input logic [4:0] exp);
    vec_t t;
    t.valid = v;   t.rs = rs;     t.tu_rs = tu_rs; t.rt = rt; t.tu_rt = tu_rt;
    t.dst = dst;   t.tnew = tnew; t.mds = mds;     t.mdd = mdd; t.mdu = mdu;
    t.exp = exp;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    d_valid = t.valid; d_rs = t.rs; d_tuse_rs = t.tu_rs; d_rt = t.rt; d_tuse_rt = t.tu_rt;
    d_dst = t.dst; d_tnew = t.tnew; d_md_start = t.mds; d_md_div = t.mdd; d_md_use = t.mdu;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic int outs();
    return 32'({stall, stall_rs, stall_rt, stall_md, busy});
  endfunction

  initial begin
    vec_t nop, divs, mfhi;
    int   n;
    nop  = mk(0, 0, N, 0, N, 0, 0, 0, 0, 0, 5'b00000);
    divs = mk(1, 0, N, 0, N, 0, 0, 1, 1, 1, 5'b00000);
    mfhi = mk(1, 0, N, 0, N, 0, 0, 0, 0, 1, 5'b00000);

    reset_n = 1'b0;
    drive(nop);
    #12;
    check("reset_outputs", outs(), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Each row is one D-stage cycle; stalled instructions are repeated until accepted.
    tv.push_back(nop);
    tv.push_back(mk(1, 1, 1, 0, N, 2, 2, 0, 0, 0, 5'b00000)); // lw $2
    tv.push_back(mk(1, 2, 1, 3, 1, 4, 1, 0, 0, 0, 5'b11000)); // add uses $2 in E
    tv.push_back(mk(1, 2, 1, 3, 1, 4, 1, 0, 0, 0, 5'b00000));
    tv.push_back(nop); tv.push_back(nop); tv.push_back(nop);
    tv.push_back(mk(1, 0, N, 0, N, 2, 2, 0, 0, 0, 5'b00000)); // lw $2
    tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000)); // beq $2,$0
    tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
    tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tv.push_back(mk(1, 6, 1, 0, N, 5, 1, 0, 0, 0, 5'b00000)); // add $5
    tv.push_back(mk(1, 7, 0, 5, 0, 0, 0, 0, 0, 0, 5'b10100)); // beq $7,$5
    tv.push_back(mk(1, 7, 0, 5, 0, 0, 0, 0, 0, 0, 5'b00000));
    tv.push_back(mk(1, 6, 1, 0, N, 0, 1, 0, 0, 0, 5'b00000)); // add to $0
    tv.push_back(mk(1, 7, 0, 5, 0, 0, 0, 0, 0, 0, 5'b00000));
    tv.push_back(mk(1, 0, N, 0, N, 8, 1, 0, 0, 0, 5'b00000)); // add $8
    tv.push_back(mk(1, 8, 0, 8, 0, 0, 0, 0, 0, 0, 5'b11100)); // beq $8,$8
    tv.push_back(mk(1, 8, 0, 8, 0, 0, 0, 0, 0, 0, 5'b00000));
    tv.push_back(mk(1, 0, N, 0, N, 9, 2, 0, 0, 0, 5'b00000)); // lw $9
    tv.push_back(mk(1, 1, 1, 9, 2, 0, 0, 0, 0, 0, 5'b00000)); // sw: tuse == tnew
    tv.push_back(mk(1, 0, N, 0, N, 10, 2, 0, 0, 0, 5'b00000)); // lw $10
    tv.push_back(mk(0, 10, 0, 0, N, 0, 0, 0, 0, 0, 5'b00000)); // squashed slot
    tv.push_back(mk(1, 10, 0, 0, N, 0, 0, 0, 0, 0, 5'b11000));
    tv.push_back(mk(1, 10, 0, 0, N, 0, 0, 0, 0, 0, 5'b00000));
    tv.push_back(mk(1, 0, N, 0, N, 0, 0, 1, 0, 1, 5'b00000)); // mult
    for (int k = 0; k < 5; k++)
      tv.push_back(mk(1, 0, N, 0, N, 11, 1, 0, 0, 1, 5'b10011)); // mfhi waits
    tv.push_back(mk(1, 0, N, 0, N, 11, 1, 0, 0, 1, 5'b00000));
    tv.push_back(mk(1, 0, N, 0, N, 12, 2, 0, 0, 0, 5'b00000));
    tv.push_back(mk(1, 12, N, 12, N, 13, 2, 0, 0, 0, 5'b00000));
    tv.push_back(mk(1, 13, N, 12, N, 14, 1, 0, 0, 0, 5'b00000));
    tv.push_back(mk(1, 14, N, 13, N, 0, 0, 0, 0, 0, 5'b00000));

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]);
      #2;
      check($sformatf("vec%0d {stall,rs,rt,md,busy}", i), outs(), 32'(tv[i].exp));
    end

    // Divide: mfhi held for exactly DIV_CYC cycles, busy drops as it proceeds.
    @(negedge clk);
    drive(divs);
    #2;
    check("div_start_no_stall", 32'(stall), 0);
    @(negedge clk);
    drive(mfhi);
    #2;
    check("div_first_busy", 32'(busy), 1);
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
      #2;
    end
    check("div_stall_cycles", n, 10);
    check("div_busy_fall", 32'(busy), 0);

    // Asynchronous reset mid-divide clears the interlock immediately.
    @(negedge clk);
    drive(divs);
    #2;
    check("div2_start_no_stall", 32'(stall), 0);
    @(negedge clk);
    drive(mfhi);
    #2;
    check("div2_mfhi_stalled", 32'(stall_md), 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_busy", 32'(busy), 0);
    check("reset_mid_stall", 32'(stall), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    check("post_reset_mfhi", outs(), 0);
    @(negedge clk);
    drive(nop);
    #2;
    check("post_reset_idle", outs(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
